vram_pixel_serializer: RTL and testbench

Parametrised video pixel serializer for the Z8 SoC family. It captures video-RAM bytes as the processor reads them during the display ISR and buffers them in a small FIFO. It shifts them out MSB-first as a 1-bit pixel stream at a programmable rate. Adds buffering, a run-time divider, double-width mode, inversion, blanking flush and error flags over the fixed 8-bit, divide-by-2 shifter in the JTC-style SoC top.

---
 rtl/vram_pixel_serializer_if.sv | 29 ++
 rtl/vram_pixel_serializer.sv | 125 ++++++++++++
 tb/tb_vram_pixel_serializer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_pixel_serializer_if.sv
// Capture/control/status bundle for the VRAM pixel serializer.
// The master drives the VRAM capture and control inputs; the slave returns the pixel stream and status.
interface vram_pixel_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int DIV_WIDTH  = 4
);
  logic                    loadStrobe;
  logic [DATA_WIDTH-1:0]   loadData;
  logic [DIV_WIDTH-1:0]    divider;
  logic                    doubleWidth;
  logic                    invert;
  logic                    blank;
  logic                    clearFlags;
  logic                    pixel;
  logic [$clog2(DEPTH):0]  fifoLevel;
  logic                    underrun;
  logic                    overrun;

  modport master (
    output loadStrobe, loadData, divider, doubleWidth, invert, blank, clearFlags,
    input  pixel, fifoLevel, underrun, overrun
  );

  modport slave (
    input  loadStrobe, loadData, divider, doubleWidth, invert, blank, clearFlags,
    output pixel, fifoLevel, underrun, overrun
  );
endinterface

// File: rtl/vram_pixel_serializer.sv
// Captures VRAM bytes read by the display ISR into a small FIFO and shifts them
// out MSB-first as a 1-bit pixel stream at a programmable rate.
module vram_pixel_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int DIV_WIDTH  = 4
) (
  input logic                   clk,
  input logic                   resetN,
  vram_pixel_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  active_q, active_d;
  logic                  half_q, half_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  ur_q, ur_d, or_q, or_d;

  logic full, empty, tick, adv, last, push, drop, pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign tick  = active_q & (div_q == '0);
  // In double-width mode only every second tick moves to the next bit.
  assign adv   = tick & (~bus.doubleWidth | half_q);
  assign last  = adv & (bit_q == BW'(DATA_WIDTH-1));
  assign push  = pending_q & ~full & ~bus.blank;
  assign drop  = pending_q &  full & ~bus.blank;
  assign pop   = ~empty & ~bus.blank & (~active_q | last);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pending_d = bus.loadStrobe & ~bus.blank;
    word_d    = word_q;
    bit_d     = bit_q;
    active_d  = active_q;
    half_d    = half_q;
    div_d     = div_q;

    if (tick) begin
      div_d  = bus.divider;
      half_d = bus.doubleWidth & ~half_q;
    end else if (active_q) begin
      div_d = div_q - DIV_WIDTH'(1);
    end

    if (adv) begin
      word_d = word_q << 1;
      bit_d  = bit_q + BW'(1);
    end
    if (last & empty) active_d = 1'b0;

    // A pop at a word boundary overrides the shift so the next MSB follows with no gap.
    if (pop) begin
      word_d   = mem_q[rd_ptr_q];
      bit_d    = '0;
      active_d = 1'b1;
      div_d    = bus.divider;
      half_d   = 1'b0;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);

    ur_d = (ur_q & ~bus.clearFlags) | (last & empty & ~bus.blank);
    or_d = (or_q & ~bus.clearFlags) | drop;

    if (bus.blank) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      active_d = 1'b0;
      div_d    = '0;
      half_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pending_q <= 1'b0;
      word_q    <= '0;
      bit_q     <= '0;
      active_q  <= 1'b0;
      half_q    <= 1'b0;
      div_q     <= '0;
      ur_q      <= 1'b0;
      or_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      active_q  <= active_d;
      half_q    <= half_d;
      div_q     <= div_d;
      ur_q      <= ur_d;
      or_q      <= or_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.loadData;
  end

  // word_q shifts left as bits advance, so its MSB is always the current bit.
  assign bus.pixel     = active_q & ~bus.blank & (word_q[DATA_WIDTH-1] ^ bus.invert);
  assign bus.fifoLevel = level_q;
  assign bus.underrun  = ur_q;
  assign bus.overrun   = or_q;
endmodule

// File: tb/tb_vram_pixel_serializer.sv
// Bench for vram_pixel_serializer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vram_pixel_serializer;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  vram_pixel_serializer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DIV_WIDTH(DIVW)) bus();

  vram_pixel_serializer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, shifter as elapsed cycles within the current word.
  logic [DW-1:0] mq[$];
  logic          m_pend = 1'b0, m_act = 1'b0, m_ur = 1'b0, m_or = 1'b0;
  logic [DW-1:0] m_word = '0;
  int            m_el = 0, m_per = 1;

  always @(posedge clk or negedge resetN) begin : model
    int lvl;
    bit do_pop, set_ur, set_or;
    if (!resetN) begin
      mq.delete();
      m_pend = 1'b0; m_act = 1'b0; m_ur = 1'b0; m_or = 1'b0; m_el = 0;
    end else begin
      lvl = mq.size(); do_pop = 0; set_ur = 0; set_or = 0;
      if (bus.blank) begin
        mq.delete();
        m_pend = 1'b0; m_act = 1'b0;
      end else begin
        if (m_act) begin
          m_el++;
          if (m_el == DW * m_per) begin
            if (lvl > 0) do_pop = 1;
            else begin m_act = 1'b0; set_ur = 1; end
          end
        end else if (lvl > 0) do_pop = 1;
        if (m_pend && lvl == DEPTH) set_or = 1;
        if (do_pop) begin
          m_word = mq.pop_front();
          m_act  = 1'b1;
          m_el   = 0;
          m_per  = (int'(bus.divider) + 1) * (bus.doubleWidth ? 2 : 1);
        end
        if (m_pend && lvl < DEPTH) mq.push_back(bus.loadData);
        m_pend = bus.loadStrobe;
      end
      m_ur = (m_ur & ~bus.clearFlags) | set_ur;
      m_or = (m_or & ~bus.clearFlags) | set_or;
    end
  end

  always @(negedge clk) begin : cmp
    logic exp_pix;
    int   idx;
    if (resetN) begin
      idx     = m_act ? (DW - 1 - m_el / m_per) : 0;
      exp_pix = m_act & ~bus.blank & (m_word[idx] ^ bus.invert);
      chk("model pixel",     bus.pixel,     exp_pix);
      chk("model fifoLevel", bus.fifoLevel, mq.size());
      chk("model underrun",  bus.underrun,  m_ur);
      chk("model overrun",   bus.overrun,   m_or);
    end
  end

  logic [DW-1:0] bd [8];
  logic [15:0]   pat_a5 = 16'b1100_1100_0011_0011;

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Strobe n consecutive loads; data bd[i] follows its strobe by one cycle.
  // Returns 2 time units after the edge that pushes the last word.
  task automatic burst(input int n);
    for (int i = 0; i <= n; i++) begin
      bus.loadStrobe = (i < n);
      bus.loadData   = (i > 0) ? bd[i-1] : '0;
      step();
    end
  endtask

  task automatic pulse_clear();
    bus.clearFlags = 1'b1; step(); bus.clearFlags = 1'b0;
  endtask

  initial begin
    bus.loadStrobe = 1'b0; bus.loadData = '0; bus.divider = '0;
    bus.doubleWidth = 1'b0; bus.invert = 1'b0; bus.blank = 1'b0; bus.clearFlags = 1'b0;
    #1;
    chk("reset pixel", bus.pixel, 0);
    chk("reset level", bus.fifoLevel, 0);
    chk("reset underrun", bus.underrun, 0);
    chk("reset overrun", bus.overrun, 0);
    step(); step();
    resetN = 1'b1;
    step();

    // Single load 0xA5, divider=1
    bus.divider = 4'd1;
    bd[0] = 8'hA5;
    burst(1);
    @(negedge clk); chk("a5 level after push", bus.fifoLevel, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("a5 pixel seq", bus.pixel, pat_a5[15-k]);
      if (k == 0) chk("a5 level after pop", bus.fifoLevel, 0);
    end
    @(negedge clk);
    chk("a5 idle pixel", bus.pixel, 0);
    chk("a5 underrun", bus.underrun, 1);
    step();

    // Burst of 7 with divider=7: five fit, two overflow
    pulse_clear();
    bus.divider = 4'd7;
    for (int i = 0; i < 7; i++) bd[i] = 8'h10 + 8'(i);
    burst(7);
    @(negedge clk);
    chk("burst level full", bus.fifoLevel, 4);
    chk("burst overrun", bus.overrun, 1);
    // clearFlags coincident with a full-FIFO push: set wins
    step();
    bus.loadStrobe = 1'b1; step();
    bus.loadStrobe = 1'b0; bus.loadData = 8'hEE; bus.clearFlags = 1'b1; step();
    @(negedge clk); chk("prio overrun held", bus.overrun, 1);
    step(); bus.clearFlags = 1'b0;
    @(negedge clk);
    chk("prio overrun cleared", bus.overrun, 0);
    chk("prio level", bus.fifoLevel, 4);

    // Blank mid-word with two words queued
    step(); bus.blank = 1'b1; step(); bus.blank = 1'b0;
    bd[0] = 8'hC3; bd[1] = 8'h5A; bd[2] = 8'h81;
    burst(3);
    @(negedge clk);
    chk("blank pre level", bus.fifoLevel, 2);
    chk("blank pre pixel", bus.pixel, 1);
    step();
    bus.blank = 1'b1; bus.loadStrobe = 1'b1; step();
    bus.loadStrobe = 1'b0; bus.loadData = 8'hFF;
    @(negedge clk);
    chk("blank level", bus.fifoLevel, 0);
    chk("blank pixel", bus.pixel, 0);
    step(); bus.blank = 1'b0;
    @(negedge clk);
    chk("blank overrun", bus.overrun, 0);
    chk("blank level after", bus.fifoLevel, 0);
    step();

    // Double width, divider=0, invert: 16 zeros, 16 ones, then idle 0
    pulse_clear();
    bus.divider = 4'd0; bus.doubleWidth = 1'b1; bus.invert = 1'b1;
    @(negedge clk); chk("dw idle pixel inverted", bus.pixel, 0);
    step();
    bd[0] = 8'hFF; bd[1] = 8'h00;
    burst(2);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("dw pixel seq", bus.pixel, (k < 16) ? 0 : 1);
    end
    @(negedge clk);
    chk("dw idle after", bus.pixel, 0);
    chk("dw underrun", bus.underrun, 1);
    step();

    // Asynchronous reset mid-stream with level 3 and active
    bus.doubleWidth = 1'b0; bus.invert = 1'b0; bus.divider = 4'd7;
    for (int i = 0; i < 4; i++) bd[i] = 8'hFF;
    burst(4);
    @(negedge clk);
    chk("rst pre level", bus.fifoLevel, 3);
    chk("rst pre pixel", bus.pixel, 1);
    #2 resetN = 1'b0;
    #1;
    chk("async rst pixel", bus.pixel, 0);
    chk("async rst level", bus.fifoLevel, 0);
    chk("async rst underrun", bus.underrun, 0);
    chk("async rst overrun", bus.overrun, 0);
    step(); resetN = 1'b1;
    step(); step();
    @(negedge clk);
    chk("post rst level", bus.fifoLevel, 0);
    chk("post rst pixel", bus.pixel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
